// File: rtl/muldiv_pkg.sv
// Shared encodings for the HI/LO multiply/divide engine.
package muldiv_pkg;

   typedef enum logic [1:0] {
      OP_MULTU = 2'b00,
      OP_MULT  = 2'b01,
      OP_DIVU  = 2'b10,
      OP_DIV   = 2'b11
   } op_e;

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_CALC = 2'b01,
      S_FIX  = 2'b10
   } state_e;

   function automatic logic op_is_signed(input op_e op);
      return (op == OP_MULT) || (op == OP_DIV);
   endfunction

endpackage

// File: rtl/muldiv_fsm.sv
// Sequencer for the multiply/divide engine: state, iteration count, and
// the busy/done/stall handshake with the core.
module muldiv_fsm
   import muldiv_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input  logic   clk,
   input  logic   rst,
   input  logic   start,
   input  logic   we_hi,
   input  logic   we_lo,
   input  logic   rd_req,
   output state_e state,
   output logic   busy,
   output logic   done,
   output logic   stall
);

   localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

   state_e           state_nxt;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_nxt;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= S_IDLE;
         cnt   <= '0;
         done  <= 1'b0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         done  <= (state == S_FIX);
      end
   end

   // NOTE: defaults first so no path through the case leaves an output
   // unassigned, which would infer a latch.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      case (state)
         S_IDLE: begin
            if (start) begin
               state_nxt = S_CALC;
               cnt_nxt   = '0;
            end
         end
         S_CALC: begin
            if (cnt == LAST_ITER) begin
               state_nxt = S_FIX;
               cnt_nxt   = '0;
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end
         S_FIX:   state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   assign busy  = (state != S_IDLE);
   assign stall = busy & (start | we_hi | we_lo | rd_req);

endmodule

// File: rtl/muldiv_unit.sv
// HI/LO owner for the MIPS core: 32-iteration shift/add multiply and
// restoring divide, sign fix-up, and MTHI/MTLO writes.
module muldiv_unit
   import muldiv_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             we_hi,
   input  logic             we_lo,
   input  logic [WIDTH-1:0] wd,
   input  logic             rd_req,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             busy,
   output logic             done,
   output logic             stall
);

   state_e state;

   muldiv_fsm #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_fsm (
      .clk    (clk),
      .rst    (rst),
      .start  (start),
      .we_hi  (we_hi),
      .we_lo  (we_lo),
      .rd_req (rd_req),
      .state  (state),
      .busy   (busy),
      .done   (done),
      .stall  (stall)
   );

   // Operand decode at issue
   logic             is_signed;
   logic             is_div;
   logic             a_neg;
   logic             b_neg;
   logic             b_zero;
   logic [WIDTH-1:0] a_mag;
   logic [WIDTH-1:0] b_mag;

   always_comb begin
      is_signed = op_is_signed(op_e'(op));
      is_div    = op[1];
      a_neg     = is_signed & a[WIDTH-1];
      b_neg     = is_signed & b[WIDTH-1];
      b_zero    = (b == '0);
      a_mag     = a_neg ? -a : a;
      b_mag     = b_neg ? -b : b;
   end

   // Engine registers: opnd is the multiplicand/divisor magnitude; acc is
   // {partial product | multiplier} or {remainder | quotient}.
   logic [WIDTH-1:0]   opnd;
   logic [2*WIDTH-1:0] acc;
   logic               div_q;
   logic               neg_lo;
   logic               neg_hi;

   logic [WIDTH:0]     mul_sum;
   logic [WIDTH:0]     div_shift;
   logic [WIDTH:0]     div_diff;
   logic [2*WIDTH-1:0] acc_nxt;

   always_comb begin
      mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
      div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
      div_diff  = div_shift - {1'b0, opnd};
      if (!div_q) begin
         acc_nxt = {mul_sum, acc[WIDTH-1:1]};
      end else if (!div_diff[WIDTH]) begin
         acc_nxt = {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
      end else begin
         acc_nxt = {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
      end
   end

   // A zero divisor leaves an all-ones quotient that must not be negated.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         opnd   <= '0;
         acc    <= '0;
         div_q  <= 1'b0;
         neg_lo <= 1'b0;
         neg_hi <= 1'b0;
      end else if (state == S_IDLE && start) begin
         opnd   <= b_mag;
         acc    <= {{WIDTH{1'b0}}, a_mag};
         div_q  <= is_div;
         neg_lo <= (a_neg ^ b_neg) & ~(is_div & b_zero);
         neg_hi <= a_neg;
      end else if (state == S_CALC) begin
         acc <= acc_nxt;
      end
   end

   logic [2*WIDTH-1:0] prod_fix;
   logic [WIDTH-1:0]   quo_fix;
   logic [WIDTH-1:0]   rem_fix;

   always_comb begin
      prod_fix = neg_lo ? -acc : acc;
      quo_fix  = neg_lo ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
      rem_fix  = neg_hi ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         hi <= '0;
         lo <= '0;
      end else if (state == S_FIX) begin
         if (div_q) begin
            hi <= rem_fix;
            lo <= quo_fix;
         end else begin
            hi <= prod_fix[2*WIDTH-1:WIDTH];
            lo <= prod_fix[WIDTH-1:0];
         end
      end else if (state == S_IDLE) begin
         if (we_hi) hi <= wd;
         if (we_lo) lo <= wd;
      end
   end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
Multi-cycle multiply/divide engine that owns the HI/LO register pair for the single-cycle MIPS core, replacing the combinational multiplier. It runs MULT, MULTU, DIV and DIVU with one shared 32-iteration shift/add-subtract engine. It also services MTHI/MTLO writes and exposes HI/LO for MFHI/MFLO. The core's control unit issues operations and freezes its PC on `stall`.

Parameters:
WIDTH, 32, operand and HI/LO width.
CNT_W, 6, iteration counter width; must satisfy 2**CNT_W > WIDTH.

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  asynchronous, active-low reset.
start  in  1  issue operation `op` on operands `a` and `b`.
op  in  2  00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
a  in  WIDTH  rs operand (multiplicand or dividend).
b  in  WIDTH  rt operand (multiplier or divisor).
we_hi  in  1  MTHI write strobe.
we_lo  in  1  MTLO write strobe.
wd  in  WIDTH  MTHI/MTLO write data.
rd_req  in  1  core is executing MFHI or MFLO this cycle.
hi  out  WIDTH  HI register.
lo  out  WIDTH  LO register.
busy  out  1  engine is not in IDLE.
done  out  1  one-cycle pulse after HI/LO are updated.
stall  out  1  combinational: busy & (start | we_hi | we_lo | rd_req).

Behaviour:
- Reset (rst low, async): state=IDLE; hi, lo, counter and internal accumulators = 0; busy=0; done=0. Reset mid-operation aborts the operation, and HI/LO read 0 on the next cycle.
- FSM states: IDLE, CALC, FIX.
  - IDLE: on a clock edge with start=1 → CALC, counter=0.
    - Latch |a| and |b| (magnitudes only for signed ops), the sign of the result, and the sign of the remainder (= sign of a).
    - Unsigned ops use the operands as-is.
  - CALC: one iteration per edge; after edge WIDTH (counter = WIDTH-1 → wrap) → FIX.
    - Multiply: shift-add into a 2*WIDTH product.
    - Divide: restoring shift-subtract; quotient builds in the low half, remainder in the high half.
  - FIX: one edge.
    - Apply sign correction, write hi/lo, pulse done next cycle, → IDLE.
    - Multiply: {hi,lo} = product, two's-complement negated if the sign bit is set.
    - Divide: lo = quotient (negated if dividend and divisor signs differ), hi = remainder (negated if the dividend is negative).
- Latency: start sampled at edge T0; busy high from after T0 through T33; HI/LO valid and done=1 in the cycle after T33 (33 cycles for WIDTH=32).
- Divide by zero (b=0): no trap. Result is hi=a (original dividend, unsigned or signed) and lo=all ones, for both DIV and DIVU. The FSM still runs the full latency.
- DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0 (natural two's-complement wrap, no special case).
- start while busy: ignored (not queued). stall stays asserted so the core holds the instruction and reissues it.
- we_hi/we_lo while busy: ignored; stall asserted. While IDLE they write wd at the edge.
- we_hi/we_lo with start in the same IDLE cycle: the writes take effect at T0 and are then overwritten by the operation result at T33.
- rd_req while busy: stall=1. The hi/lo outputs show the previous values and are not forwarded mid-operation.
- hi/lo only change at reset, at a FIX edge, or on an IDLE-state MTHI/MTLO edge.
- done is registered: high for exactly one cycle, never coincident with busy.

Decomposition:
- Package muldiv_pkg holds:
  - op encodings: OP_MULTU, OP_MULT, OP_DIVU, OP_DIV;
  - state encodings: S_IDLE, S_CALC, S_FIX.
- One natural sub-module: muldiv_fsm. It holds the state register, the iteration counter, and the busy/done/stall generation.
- muldiv_unit instantiates muldiv_fsm and holds the operand/accumulator registers, the add/subtract engine and the sign fix-up.

Test Plan:
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF → after 33 cycles hi=0xFFFFFFFE, lo=0x00000001, done pulses once, busy=1 for 33 cycles.
- MULT a=0xFFFFFFFD (-3), b=7 → hi=0xFFFFFFFF, lo=0xFFFFFFEB. Then DIV a=0xFFFFFFF9 (-7), b=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIVU a=0x64, b=0 → hi=0x00000064, lo=0xFFFFFFFF. DIV a=0x80000000, b=0xFFFFFFFF → lo=0x80000000, hi=0.
- Hazards:
  - Issue MULTU 5*6, then at cycle 10 assert rd_req, start and we_hi → stall=1 each cycle, hi/lo unchanged (prior values), and start/we_hi ignored.
  - Final result is hi=0, lo=30.
- In IDLE, we_hi with wd=0x1234 and next cycle we_lo with wd=0x5678 → hi=0x1234, lo=0x5678, busy stays 0, stall=0.
- Drop rst low at CALC cycle 15 of DIVU 100/7 → asynchronously busy=0, hi=lo=0. After release, a new DIVU 100/7 yields lo=14, hi=2.
